// File: rtl/trace_capture_buffer.sv
// Circular trace buffer: records {pc, instr, mar} samples around a trigger event,
// then drains them oldest-first through a valid/ready read port.
module trace_capture_buffer #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int MAR_W   = 32,
   parameter int DEPTH   = 16,
   parameter int POST_W  = 8,
   parameter int PTR_W   = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cap_valid,
   input  logic [PC_W-1:0]    cap_pc,
   input  logic [INSTR_W-1:0] cap_instr,
   input  logic [MAR_W-1:0]   cap_mar,
   input  logic               arm,
   input  logic [1:0]         trig_mode,
   input  logic [31:0]        trig_value,
   input  logic [POST_W-1:0]  post_len,
   input  logic               rd_ready,
   output logic               rd_valid,
   output logic [PC_W-1:0]    rd_pc,
   output logic [INSTR_W-1:0] rd_instr,
   output logic [MAR_W-1:0]   rd_mar,
   output logic [1:0]         state,
   output logic [PTR_W:0]     count,
   output logic               wrapped
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [PTR_W:0]    FULL_C     = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE_C  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE_C  = PTR_W'(1);
   localparam logic [POST_W-1:0] POST_ONE_C = POST_W'(1);

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]      count_q, count_d;
   logic                wrapped_q, wrapped_d;
   logic [POST_W-1:0]   post_q, post_d;
   logic                wr_en_s;
   logic                trig_hit_s;
   logic                rd_valid_s;

   logic [PC_W-1:0]     pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0]  instr_mem_q [DEPTH];
   logic [MAR_W-1:0]    mar_mem_q   [DEPTH];

   assign rd_valid_s = (state_q == ST_DONE) && (count_q != {(PTR_W+1){1'b0}});

   // Trigger comparator for the current capture sample
   always_comb begin
      trig_hit_s = 1'b0;
      case (trig_mode)
         2'd0:    trig_hit_s = 1'b1;
         2'd1:    trig_hit_s = (cap_pc == trig_value[PC_W-1:0]);
         2'd2:    trig_hit_s = (cap_instr[31:26] == trig_value[5:0]);
         default: trig_hit_s = 1'b0;
      endcase
   end

   // Next-state logic: arm restart, capture/trigger sequencing and read-out
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      wrapped_d = wrapped_q;
      post_d    = post_q;
      wr_en_s   = 1'b0;
      if (arm) begin
         state_d   = ST_ARMED;
         wr_ptr_d  = {PTR_W{1'b0}};
         rd_ptr_d  = {PTR_W{1'b0}};
         count_d   = {(PTR_W+1){1'b0}};
         wrapped_d = 1'b0;
         post_d    = {POST_W{1'b0}};
      end else begin
         case (state_q)
            ST_ARMED, ST_POST: begin
               if (cap_valid) begin
                  wr_en_s  = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE_C;
                  if (count_q == FULL_C) begin
                     wrapped_d = 1'b1;
                  end else begin
                     count_d = count_q + CNT_ONE_C;
                  end
                  if (state_q == ST_ARMED) begin
                     if (trig_hit_s) begin
                        if (post_len == {POST_W{1'b0}}) begin
                           state_d = ST_DONE;
                        end else begin
                           state_d = ST_POST;
                           post_d  = post_len;
                        end
                     end else begin
                        state_d = ST_ARMED;
                     end
                  end else begin
                     post_d = post_q - POST_ONE_C;
                     if (post_q == POST_ONE_C) begin
                        state_d = ST_DONE;
                     end else begin
                        state_d = ST_POST;
                     end
                  end
                  // Point the reader at the oldest surviving entry
                  if (state_d == ST_DONE) begin
                     rd_ptr_d = wr_ptr_d - count_d[PTR_W-1:0];
                  end else begin
                     rd_ptr_d = rd_ptr_q;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_DONE: begin
               if (rd_valid_s && rd_ready) begin
                  rd_ptr_d = rd_ptr_q + PTR_ONE_C;
                  count_d  = count_q - CNT_ONE_C;
               end else begin
                  rd_ptr_d = rd_ptr_q;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= {PTR_W{1'b0}};
         rd_ptr_q  <= {PTR_W{1'b0}};
         count_q   <= {(PTR_W+1){1'b0}};
         wrapped_q <= 1'b0;
         post_q    <= {POST_W{1'b0}};
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
         post_q    <= post_d;
      end
   end

   // Sample storage, deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         pc_mem_q[wr_ptr_q]    <= cap_pc;
         instr_mem_q[wr_ptr_q] <= cap_instr;
         mar_mem_q[wr_ptr_q]   <= cap_mar;
      end
   end

   // Read data is zeroed whenever no entry is being presented
   always_comb begin
      if (rd_valid_s) begin
         rd_pc    = pc_mem_q[rd_ptr_q];
         rd_instr = instr_mem_q[rd_ptr_q];
         rd_mar   = mar_mem_q[rd_ptr_q];
      end else begin
         rd_pc    = {PC_W{1'b0}};
         rd_instr = {INSTR_W{1'b0}};
         rd_mar   = {MAR_W{1'b0}};
      end
   end

   assign rd_valid = rd_valid_s;
   assign state    = state_q;
   assign count    = count_q;
   assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed self-checking bench for trace_capture_buffer (DEPTH=16 defaults).
module tb_trace_capture_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cap_valid;
   logic [31:0] cap_pc;
   logic [31:0] cap_instr;
   logic [31:0] cap_mar;
   logic        arm;
   logic [1:0]  trig_mode;
   logic [31:0] trig_value;
   logic [7:0]  post_len;
   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_pc;
   logic [31:0] rd_instr;
   logic [31:0] rd_mar;
   logic [1:0]  state;
   logic [4:0]  count;
   logic        wrapped;

   int vectors = 0;
   int miscompares = 0;

   trace_capture_buffer dut (
      .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_pc(cap_pc),
      .cap_instr(cap_instr), .cap_mar(cap_mar), .arm(arm), .trig_mode(trig_mode),
      .trig_value(trig_value), .post_len(post_len), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_mar(rd_mar),
      .state(state), .count(count), .wrapped(wrapped)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic cap(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] mar);
      cap_valid = 1'b1;
      cap_pc    = pc;
      cap_instr = instr;
      cap_mar   = mar;
      tick();
      cap_valid = 1'b0;
   endtask

   task automatic test_reset();
      vectors++;
      if (state !== 2'd0 || count !== 5'd0 || rd_valid !== 1'b0 || wrapped !== 1'b0 || rd_pc !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: got st=%0d cnt=%0d v=%0b w=%0b pc=%0h want 0 0 0 0 0", state, count, rd_valid, wrapped, rd_pc);
      end
   endtask

   task automatic test_immediate();
      trig_mode = 2'd0; post_len = 8'd3;
      do_arm();
      vectors++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL imm_armed: got %0d want 1", state); end
      for (int i = 0; i < 5; i++) begin
         cap(32'(i*4), 32'hA000_0000 | 32'(i*4), 32'(i*4+1));
         vectors++;
         if (state !== ((i < 3) ? 2'd2 : 2'd3)) begin
            miscompares++; $display("FAIL imm_state[%0d]: got %0d want %0d", i, state, (i < 3) ? 2 : 3);
         end
      end
      vectors++;
      if (count !== 5'd4 || wrapped !== 1'b0) begin miscompares++; $display("FAIL imm_count: got %0d/%0b want 4/0", count, wrapped); end
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (rd_valid !== 1'b1 || rd_pc !== 32'(i*4) || rd_instr !== (32'hA000_0000 | 32'(i*4)) || rd_mar !== 32'(i*4+1)) begin
            miscompares++; $display("FAIL imm_read[%0d]: got v=%0b pc=%0h want v=1 pc=%0h", i, rd_valid, rd_pc, i*4);
         end
         tick();
      end
      vectors++;
      if (rd_valid !== 1'b0 || rd_pc !== 32'd0 || count !== 5'd0 || state !== 2'd3) begin
         miscompares++; $display("FAIL imm_drained: got v=%0b pc=%0h cnt=%0d st=%0d want 0 0 0 3", rd_valid, rd_pc, count, state);
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_pc_match();
      logic [1:0] exp_st;
      trig_mode = 2'd1; trig_value = 32'd80; post_len = 8'd2;
      do_arm();
      for (int pc = 0; pc <= 100; pc += 4) begin
         cap(32'(pc), 32'(pc), 32'(pc + 7));
         exp_st = (pc < 80) ? 2'd1 : ((pc < 88) ? 2'd2 : 2'd3);
         vectors++;
         if (state !== exp_st) begin miscompares++; $display("FAIL pcm_state[pc=%0d]: got %0d want %0d", pc, state, exp_st); end
      end
      vectors++;
      if (count !== 5'd16 || wrapped !== 1'b1) begin miscompares++; $display("FAIL pcm_count: got %0d/%0b want 16/1", count, wrapped); end
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         vectors++;
         if (rd_valid !== 1'b1 || rd_pc !== 32'(28 + 4*i) || rd_mar !== 32'(35 + 4*i)) begin
            miscompares++; $display("FAIL pcm_read[%0d]: got v=%0b pc=%0d want v=1 pc=%0d", i, rd_valid, rd_pc, 28 + 4*i);
         end
         tick();
      end
      vectors++;
      if (rd_valid !== 1'b0 || count !== 5'd0) begin miscompares++; $display("FAIL pcm_drained: got v=%0b cnt=%0d want 0 0", rd_valid, count); end
      rd_ready = 1'b0;
   endtask

   task automatic test_opcode();
      trig_mode = 2'd2; trig_value = 32'h0000_0023; post_len = 8'd0;
      do_arm();
      cap(32'h200, {6'h00, 26'h1}, 32'h300);
      vectors++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL opc_no_trig0: got %0d want 1", state); end
      cap(32'h204, {6'h08, 26'h2}, 32'h304);
      vectors++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL opc_no_trig8: got %0d want 1", state); end
      cap(32'h208, {6'h23, 26'h3}, 32'h308);
      vectors++;
      if (state !== 2'd3 || count !== 5'd3) begin miscompares++; $display("FAIL opc_trig: got st=%0d cnt=%0d want 3 3", state, count); end
   endtask

   task automatic test_stall();
      rd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (rd_valid !== 1'b1 || rd_pc !== 32'h200 || rd_instr !== 32'h0000_0001 || rd_mar !== 32'h300 || count !== 5'd3) begin
            miscompares++; $display("FAIL stall_hold[%0d]: got v=%0b pc=%0h ins=%0h mar=%0h cnt=%0d want 1 200 1 300 3", i, rd_valid, rd_pc, rd_instr, rd_mar, count);
         end
         tick();
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (count !== 5'(3 - i) || rd_pc !== 32'(32'h200 + 4*i) || rd_mar !== 32'(32'h300 + 4*i)) begin
            miscompares++; $display("FAIL stall_pop[%0d]: got cnt=%0d pc=%0h want cnt=%0d pc=%0h", i, count, rd_pc, 3 - i, 32'h200 + 4*i);
         end
         tick();
      end
      vectors++;
      if (rd_valid !== 1'b0 || rd_pc !== 32'd0 || rd_instr !== 32'd0 || rd_mar !== 32'd0 || state !== 2'd3) begin
         miscompares++; $display("FAIL stall_empty: got v=%0b pc=%0h ins=%0h mar=%0h st=%0d want 0 0 0 0 3", rd_valid, rd_pc, rd_instr, rd_mar, state);
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      trig_mode = 2'd0; post_len = 8'd10;
      do_arm();
      cap(32'h10, 32'h11, 32'h12);
      cap(32'h14, 32'h15, 32'h16);
      vectors++;
      if (state !== 2'd2 || count !== 5'd2) begin miscompares++; $display("FAIL ares_pre: got st=%0d cnt=%0d want 2 2", state, count); end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (state !== 2'd0 || count !== 5'd0 || rd_valid !== 1'b0) begin
         miscompares++; $display("FAIL ares_immediate: got st=%0d cnt=%0d v=%0b want 0 0 0", state, count, rd_valid);
      end
      #1 reset = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) cap(32'(i), 32'(i), 32'(i));
      vectors++;
      if (state !== 2'd0 || count !== 5'd0) begin miscompares++; $display("FAIL ares_ignored: got st=%0d cnt=%0d want 0 0", state, count); end
      do_arm();
      vectors++;
      if (state !== 2'd1 || count !== 5'd0) begin miscompares++; $display("FAIL ares_rearm: got st=%0d cnt=%0d want 1 0", state, count); end
   endtask

   task automatic test_arm_in_post();
      trig_mode = 2'd0; post_len = 8'd20;
      do_arm();
      for (int i = 0; i < 18; i++) cap(32'(i), 32'(i), 32'(i));
      vectors++;
      if (state !== 2'd2 || count !== 5'd16 || wrapped !== 1'b1) begin
         miscompares++; $display("FAIL aip_pre: got st=%0d cnt=%0d w=%0b want 2 16 1", state, count, wrapped);
      end
      arm = 1'b1;
      cap(32'hDEAD, 32'hBEEF, 32'hCAFE);
      arm = 1'b0;
      vectors++;
      if (state !== 2'd1 || count !== 5'd0 || wrapped !== 1'b0 || rd_valid !== 1'b0) begin
         miscompares++; $display("FAIL aip_rearm: got st=%0d cnt=%0d w=%0b v=%0b want 1 0 0 0", state, count, wrapped, rd_valid);
      end
      post_len = 8'd0;
      cap(32'h100, 32'h101, 32'h102);
      vectors++;
      if (state !== 2'd3 || count !== 5'd1 || rd_pc !== 32'h100) begin
         miscompares++; $display("FAIL aip_capture: got st=%0d cnt=%0d pc=%0h want 3 1 100", state, count, rd_pc);
      end
   endtask

   initial begin
      reset = 1'b0; cap_valid = 1'b0; cap_pc = 32'd0; cap_instr = 32'd0; cap_mar = 32'd0;
      arm = 1'b0; trig_mode = 2'd3; trig_value = 32'd0; post_len = 8'd0; rd_ready = 1'b0;
      tick();
      tick();
      test_reset();
      reset = 1'b1;
      tick();
      test_reset();
      test_immediate();
      test_pc_match();
      test_opcode();
      test_stall();
      test_async_reset();
      test_arm_in_post();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
